// File: rtl/vram_init_seq.sv
// vram_init_seq: table-driven VRAM fill sequencer followed by a vsync-paced
// scroll register writer.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                pulse, re-runs the sequence from IDLE or SCROLL
//   vsync                frame sync (synchronous to clk)
//   reg_valid/base/len/mode/seed/step  packed per-region fill descriptors
//   busy, done           status (DELAY/FILL, SCROLL)
//   mem_en, mem_we, mem_addr, mem_din, mem_ready  write request with backpressure
module vram_init_seq #(
    parameter int unsigned       NUM_REGIONS     = 8,
    parameter int unsigned       ADDR_W          = 32,
    parameter int unsigned       DATA_W          = 32,
    parameter int unsigned       CNT_W           = 16,
    parameter int unsigned       STARTUP_DELAY   = 100,
    parameter bit                AUTO_START      = 1'b1,
    parameter logic [ADDR_W-1:0] SCROLL_ADDR     = ADDR_W'(32'h0600_028F),
    parameter logic [DATA_W-1:0] SCROLL_FLAGS    = DATA_W'(32'h8000_0000),
    parameter int unsigned       FRAMES_PER_STEP = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          vsync,
    input  logic [NUM_REGIONS-1:0]        reg_valid,
    input  logic [NUM_REGIONS*ADDR_W-1:0] reg_base,
    input  logic [NUM_REGIONS*CNT_W-1:0]  reg_len,
    input  logic [NUM_REGIONS*2-1:0]      reg_mode,
    input  logic [NUM_REGIONS*DATA_W-1:0] reg_seed,
    input  logic [NUM_REGIONS*CNT_W-1:0]  reg_step,
    output logic                          busy,
    output logic                          done,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_din,
    input  logic                          mem_ready
);

    localparam int unsigned RIDX_W   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int unsigned DLY_W    = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY) : 1;
    localparam int unsigned DLY_LAST = (STARTUP_DELAY > 0) ? STARTUP_DELAY - 1 : 0;
    localparam int unsigned FC_W     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int unsigned FC_LAST  = (FRAMES_PER_STEP > 0) ? FRAMES_PER_STEP - 1 : 0;

    localparam logic [RIDX_W-1:0] LAST_REGION = RIDX_W'(NUM_REGIONS - 1);
    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_INC   = 2'd1;
    localparam logic [1:0] MODE_DIV   = 2'd2;
    localparam logic [1:0] MODE_MOD   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_FILL, S_SCROLL} state_t;
    localparam state_t RUN_STATE = (STARTUP_DELAY == 0) ? S_FILL : S_DELAY;

    state_t              state, state_d;
    logic                auto_pend;
    logic [DLY_W-1:0]    dly_cnt;
    logic [RIDX_W-1:0]   ridx;
    logic                active;
    logic [CNT_W-1:0]    remain;
    logic [1:0]          mode_q;
    logic [CNT_W-1:0]    step_q;
    logic [DATA_W-1:0]   seed_q;
    logic [CNT_W-1:0]    sub_cnt;
    logic                vsync_q;
    logic [FC_W-1:0]     frame_cnt;
    logic [8:0]          scroll_x;
    logic [7:0]          scroll_y;

    logic                cur_valid;
    logic [ADDR_W-1:0]   cur_base;
    logic [CNT_W-1:0]    cur_len;
    logic [1:0]          cur_mode;
    logic [DATA_W-1:0]   cur_seed;
    logic [CNT_W-1:0]    cur_step;
    logic                cur_use;
    logic                accept;
    logic                last_region;
    logic                fill_exit;
    logic [DATA_W-1:0]   din_next;
    logic [CNT_W-1:0]    sub_next;
    logic [CNT_W-1:0]    sub_inc;
    logic                vs_rise;
    logic                step_now;
    logic [8:0]          x_new;
    logic [7:0]          y_new;
    logic [DATA_W-1:0]   scroll_data;

    assign mem_we = mem_en;

    // Descriptor of the region currently being evaluated.
    always_comb begin
        cur_valid = 1'b0;
        cur_base  = '0;
        cur_len   = '0;
        cur_mode  = MODE_CONST;
        cur_seed  = '0;
        cur_step  = '0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (ridx == RIDX_W'(i)) begin
                cur_valid = reg_valid[i];
                cur_base  = reg_base[i*ADDR_W +: ADDR_W];
                cur_len   = reg_len[i*CNT_W +: CNT_W];
                cur_mode  = reg_mode[i*2 +: 2];
                cur_seed  = reg_seed[i*DATA_W +: DATA_W];
                cur_step  = reg_step[i*CNT_W +: CNT_W];
            end
        end
    end

    assign cur_use     = cur_valid && (cur_len != '0);
    assign accept      = mem_en && mem_ready;
    assign last_region = (ridx == LAST_REGION);
    assign fill_exit   = (state == S_FILL) && last_region &&
                         ((!active && !cur_use) ||
                          (active && accept && (remain == CNT_W'(1))));

    // Next data word from running counters; step 0 pins DIV/MOD to the seed.
    always_comb begin
        din_next = mem_din;
        sub_next = sub_cnt;
        sub_inc  = sub_cnt + CNT_W'(1);
        unique case (mode_q)
            MODE_CONST: din_next = mem_din;
            MODE_INC:   din_next = mem_din + DATA_W'(step_q);
            MODE_DIV: begin
                if (step_q != '0) begin
                    if (sub_inc == step_q) begin
                        sub_next = '0;
                        din_next = mem_din + DATA_W'(1);
                    end else begin
                        sub_next = sub_inc;
                    end
                end
            end
            MODE_MOD: begin
                if (step_q != '0) begin
                    if (sub_inc == step_q) begin
                        sub_next = '0;
                        din_next = seed_q;
                    end else begin
                        sub_next = sub_inc;
                        din_next = mem_din + DATA_W'(1);
                    end
                end
            end
            default: din_next = mem_din;
        endcase
    end

    // Scroll edge detect and post-edge counter values.
    assign vs_rise     = vsync && !vsync_q;
    assign step_now    = (frame_cnt == FC_W'(FC_LAST));
    assign x_new       = step_now ? scroll_x + 9'd1 : scroll_x;
    assign y_new       = step_now ? scroll_y + 8'd1 : scroll_y;
    assign scroll_data = SCROLL_FLAGS | DATA_W'({x_new, 8'h00}) | DATA_W'(y_new);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:   if (start || auto_pend) state_d = RUN_STATE;
            S_DELAY:  if (dly_cnt == DLY_W'(DLY_LAST)) state_d = S_FILL;
            S_FILL:   if (fill_exit) state_d = S_SCROLL;
            S_SCROLL: if (start) state_d = RUN_STATE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_pend <= AUTO_START;
            dly_cnt   <= '0;
            ridx      <= '0;
            active    <= 1'b0;
            remain    <= '0;
            mode_q    <= MODE_CONST;
            step_q    <= '0;
            seed_q    <= '0;
            sub_cnt   <= '0;
            vsync_q   <= 1'b0;
            frame_cnt <= '0;
            scroll_x  <= '0;
            scroll_y  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
        end else begin
            vsync_q <= vsync;
            busy    <= (state_d == S_DELAY) || (state_d == S_FILL);
            done    <= (state_d == S_SCROLL);
            if (state == S_IDLE) auto_pend <= 1'b0;

            if (state == S_DELAY) dly_cnt <= dly_cnt + DLY_W'(1);
            else                  dly_cnt <= '0;

            unique case (state)
                S_FILL: begin
                    if (!active) begin
                        // Entry cycle: latch descriptor or skip the region.
                        if (cur_use) begin
                            active   <= 1'b1;
                            remain   <= cur_len;
                            mode_q   <= cur_mode;
                            step_q   <= cur_step;
                            seed_q   <= cur_seed;
                            sub_cnt  <= '0;
                            mem_en   <= 1'b1;
                            mem_addr <= cur_base;
                            mem_din  <= cur_seed;
                        end else if (!last_region) begin
                            ridx <= ridx + RIDX_W'(1);
                        end
                    end else if (accept) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        mem_din  <= din_next;
                        sub_cnt  <= sub_next;
                        remain   <= remain - CNT_W'(1);
                        if (remain == CNT_W'(1)) begin
                            active <= 1'b0;
                            mem_en <= 1'b0;
                            if (!last_region) ridx <= ridx + RIDX_W'(1);
                        end
                    end
                end
                S_SCROLL: begin
                    if (start) begin
                        mem_en    <= 1'b0;
                        frame_cnt <= '0;
                    end else if (vs_rise) begin
                        // A newer edge overwrites any still-pending write.
                        if (step_now) begin
                            frame_cnt <= '0;
                            scroll_x  <= x_new;
                            scroll_y  <= y_new;
                        end else begin
                            frame_cnt <= frame_cnt + FC_W'(1);
                        end
                        mem_en   <= 1'b1;
                        mem_addr <= SCROLL_ADDR;
                        mem_din  <= scroll_data;
                    end else if (accept) begin
                        mem_en <= 1'b0;
                    end
                end
                default: begin
                end
            endcase

            if ((state != S_FILL) && (state_d == S_FILL)) begin
                ridx   <= '0;
                active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_init_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for vram_init_seq: stimulus pushes expected writes computed
// from the fill/scroll rules, a forked monitor pops and compares on accept.
module tb_vram_init_seq;
    localparam int unsigned NR = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam logic [31:0] SC_ADDR = 32'h0600_028F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic vsync = 1'b0;
    logic mem_ready = 1'b1;
    logic [NR-1:0]    reg_valid;
    logic [NR*AW-1:0] reg_base;
    logic [NR*CW-1:0] reg_len;
    logic [NR*2-1:0]  reg_mode;
    logic [NR*DW-1:0] reg_seed;
    logic [NR*CW-1:0] reg_step;
    logic busy, done, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;

    vram_init_seq #(
        .NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW),
        .STARTUP_DELAY(100), .AUTO_START(1'b1),
        .SCROLL_ADDR(SC_ADDR), .SCROLL_FLAGS(32'h8000_0000),
        .FRAMES_PER_STEP(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .vsync(vsync),
        .reg_valid(reg_valid), .reg_base(reg_base), .reg_len(reg_len),
        .reg_mode(reg_mode), .reg_seed(reg_seed), .reg_step(reg_step),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] a; logic [31:0] d; } exp_t;
    exp_t sbq[$];

    int compared = 0;
    int mismatched = 0;
    int wr_cnt = 0;
    int ready_mode = 0;
    logic [31:0] last_data = '0;

    bit          cfg_valid [NR];
    logic [31:0] cfg_base  [NR];
    int unsigned cfg_len   [NR];
    int unsigned cfg_mode  [NR];
    logic [31:0] cfg_seed  [NR];
    int unsigned cfg_step  [NR];

    int sc_frames = 0;
    int sc_steps  = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cfg();
        for (int r = 0; r < NR; r++) begin
            cfg_valid[r] = 1'b0; cfg_base[r] = 32'(r) << 16; cfg_len[r] = 0;
            cfg_mode[r] = 0; cfg_seed[r] = '0; cfg_step[r] = 0;
        end
    endtask

    task automatic apply_cfg();
        for (int r = 0; r < NR; r++) begin
            reg_valid[r]             = cfg_valid[r];
            reg_base[r*AW +: AW]     = cfg_base[r];
            reg_len[r*CW +: CW]      = CW'(cfg_len[r]);
            reg_mode[r*2 +: 2]       = 2'(cfg_mode[r]);
            reg_seed[r*DW +: DW]     = cfg_seed[r];
            reg_step[r*CW +: CW]     = CW'(cfg_step[r]);
        end
    endtask

    // Word k of region r straight from the mode definitions.
    function automatic logic [31:0] model_word(int r, int unsigned k);
        int unsigned s = cfg_step[r];
        case (cfg_mode[r])
            1:       return cfg_seed[r] + 32'(k * s);
            2:       return (s == 0) ? cfg_seed[r] : cfg_seed[r] + 32'(k / s);
            3:       return (s == 0) ? cfg_seed[r] : cfg_seed[r] + 32'(k % s);
            default: return cfg_seed[r];
        endcase
    endfunction

    task automatic push_fill();
        for (int r = 0; r < NR; r++)
            if (cfg_valid[r] && cfg_len[r] != 0)
                for (int unsigned k = 0; k < cfg_len[r]; k++)
                    sbq.push_back('{a: cfg_base[r] + 32'(k), d: model_word(r, k)});
    endtask

    task automatic scroll_edge(output exp_t e);
        sc_frames++;
        if (sc_frames == 4) begin
            sc_frames = 0;
            sc_steps++;
        end
        e.a = SC_ADDR;
        e.d = 32'h8000_0000 | (32'(sc_steps % 512) << 8) | 32'(sc_steps % 256);
    endtask

    task automatic vs_pulse();
        exp_t e;
        scroll_edge(e);
        sbq.push_back(e);
        vsync = 1'b1; cyc();
        vsync = 1'b0; cyc(); cyc();
    endtask

    task automatic pulse_start();
        sc_frames = 0;
        start = 1'b1; cyc();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(string name, int budget);
        int c = 0;
        while (!done && c < budget) begin
            cyc();
            c++;
        end
        compared++;
        if (!done) begin
            mismatched++;
            $display("FAIL %s_timeout: done=%0b after %0d cycles, want 1", name, done, c);
        end else begin
            chk({name, "_mem_en_first_scroll"}, 32'(mem_en), 32'd0);
            chk({name, "_busy_in_scroll"}, 32'(busy), 32'd0);
            chk({name, "_drain"}, 32'(sbq.size()), 32'd0);
        end
    endtask

    task automatic first_en_latency(string name);
        int c = 0;
        while (!mem_en && c < 200) begin
            cyc();
            c++;
        end
        compared++;
        if (c <= 100 || c > 104) begin
            mismatched++;
            $display("FAIL %s_latency: first mem_en after %0d cycles, want 101..104", name, c);
        end
    endtask

    task automatic monitor();
        logic stalled = 1'b0;
        logic [31:0] h_a = '0, h_d = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                chk("hold_en", 32'(mem_en), 32'd1);
                chk("hold_addr", mem_addr, h_a);
                chk("hold_data", mem_din, h_d);
            end
            stalled = mem_en && !mem_ready && busy;
            h_a = mem_addr;
            h_d = mem_din;
            if (mem_en && mem_ready) begin
                wr_cnt++;
                last_data = mem_din;
                if (sbq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: addr %h data %h, want no write", mem_addr, mem_din);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_data", mem_din, e.d);
                    chk("wr_we", 32'(mem_we), 32'd1);
                end
            end
        end
    endtask

    task automatic ready_drv();
        int p = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = 1'($urandom_range(0, 1));
                2:       begin mem_ready = ((p % 4) == 0) || ((p % 4) == 3); p++; end
                default: mem_ready = 1'b0;
            endcase
        end
    endtask

    initial begin
        int w0;
        int c;
        exp_t e;
        fork
            monitor();
            ready_drv();
        join_none

        // Reset state and the auto-started CONST fill.
        clear_cfg();
        cfg_valid[0] = 1'b1; cfg_base[0] = 32'h0610_0000; cfg_len[0] = 4;
        cfg_mode[0] = 0; cfg_seed[0] = 32'd5;
        apply_cfg();
        repeat (3) cyc();
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_din", mem_din, 32'd0);
        push_fill();
        rst = 1'b0;
        first_en_latency("auto");
        wait_done("const", 400);

        // Scroll: fourth edge steps x/y, then run to a full x wrap.
        for (int i = 0; i < 4; i++) vs_pulse();
        chk("scroll_4th", last_data, 32'h8000_0101);
        for (int i = 4; i < 2048; i++) vs_pulse();
        chk("scroll_wrap", last_data, 32'h8000_0000);
        chk("scroll_drain", 32'(sbq.size()), 32'd0);

        // Edges while a write is stalled collapse into one write.
        ready_mode = 3;
        cyc(); cyc();
        scroll_edge(e);
        vsync = 1'b1; cyc(); vsync = 1'b0; cyc(); cyc();
        scroll_edge(e);
        sbq.push_back(e);
        w0 = wr_cnt;
        vsync = 1'b1; cyc(); vsync = 1'b0; cyc(); cyc();
        ready_mode = 0;
        repeat (4) cyc();
        chk("pending_writes", 32'(wr_cnt - w0), 32'd1);
        chk("pending_drain", 32'(sbq.size()), 32'd0);

        // Directed table: skipped regions, INC/DIV/MOD, 1-0-0-1 backpressure,
        // start during FILL ignored.
        clear_cfg();
        cfg_valid[0] = 1'b1; cfg_base[0] = 32'h0000_1000; cfg_len[0] = 5;
        cfg_mode[0] = 1; cfg_seed[0] = 32'h10; cfg_step[0] = 3;
        cfg_valid[1] = 1'b0; cfg_base[1] = 32'h0000_2000; cfg_len[1] = 6;
        cfg_valid[2] = 1'b1; cfg_base[2] = 32'h0000_3000; cfg_len[2] = 0;
        cfg_valid[3] = 1'b0; cfg_base[3] = 32'h0000_4000; cfg_len[3] = 6;
        cfg_valid[4] = 1'b1; cfg_base[4] = 32'h0000_5000; cfg_len[4] = 130;
        cfg_mode[4] = 2; cfg_seed[4] = 32'd0; cfg_step[4] = 64;
        cfg_valid[5] = 1'b1; cfg_base[5] = 32'h0000_6000; cfg_len[5] = 9;
        cfg_mode[5] = 3; cfg_seed[5] = 32'd0; cfg_step[5] = 7;
        apply_cfg();
        push_fill();
        ready_mode = 2;
        pulse_start();
        repeat (110) cyc();
        start = 1'b1; cyc(); start = 1'b0;
        wait_done("table", 1500);
        ready_mode = 0;
        for (int i = 0; i < 3; i++) vs_pulse();

        // Random descriptor tables under random backpressure.
        for (int it = 0; it < 6; it++) begin
            for (int r = 0; r < NR; r++) begin
                cfg_valid[r] = ($urandom_range(0, 3) != 0);
                cfg_base[r]  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFA : $urandom();
                cfg_len[r]   = $urandom_range(0, 12);
                cfg_mode[r]  = $urandom_range(0, 3);
                cfg_seed[r]  = $urandom();
                cfg_step[r]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 65535))
                                                           : $urandom_range(0, 9);
            end
            apply_cfg();
            push_fill();
            ready_mode = 1;
            pulse_start();
            wait_done("random", 2000);
            ready_mode = 0;
            for (int i = 0; i < 3; i++) vs_pulse();
        end

        // Reset while word 2 of region 0 is on the bus.
        clear_cfg();
        cfg_valid[0] = 1'b1; cfg_base[0] = 32'h0700_0000; cfg_len[0] = 8;
        cfg_mode[0] = 1; cfg_seed[0] = 32'd1; cfg_step[0] = 2;
        apply_cfg();
        push_fill();
        ready_mode = 0;
        pulse_start();
        w0 = wr_cnt;
        c = 0;
        while (wr_cnt < w0 + 2 && c < 300) begin
            cyc();
            c++;
        end
        chk("mid_fill_reached", 32'(wr_cnt - w0 >= 2), 32'd1);
        chk("mid_fill_word2", mem_addr, 32'h0700_0002);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_mem_en", 32'(mem_en), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_addr", mem_addr, 32'd0);
        chk("async_rst_din", mem_din, 32'd0);
        sbq.delete();
        sc_frames = 0;
        sc_steps = 0;
        push_fill();
        @(posedge clk);
        #1 rst = 1'b0;
        first_en_latency("restart");
        wait_done("restart", 400);
        for (int i = 0; i < 4; i++) vs_pulse();
        chk("restart_scroll", last_data, 32'h8000_0101);
        chk("final_drain", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/vram_init_seq.md
Name: vram_init_seq

Overview:
- Table-driven VRAM initialisation sequencer with a frame-synchronous scroll writer.
- Replaces hard-coded CPU-side init loops with NUM_REGIONS programmable fill descriptors, written over the shared mem bus with ready backpressure.
- After the last region, it writes one scroll register per vsync rising edge, every FRAMES_PER_STEP frames.
- Sits between the system controller and the VRAM arbiter, ahead of the PPU.

Parameters:
- NUM_REGIONS, 8, number of fill descriptors.
- ADDR_W, 32, mem address width.
- DATA_W, 32, mem data width.
- CNT_W, 16, region length and count width.
- STARTUP_DELAY, 100, idle cycles before the first region (0 allowed).
- AUTO_START, 1, 1 = run the sequence automatically after reset release.
- SCROLL_ADDR, 32'h0600_028F, target word address for the scroll write.
- SCROLL_FLAGS, 32'h8000_0000, constant OR-ed into scroll data.
- FRAMES_PER_STEP, 4, vsync edges per scroll increment (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  pulse; re-run the sequence from IDLE or SCROLL.
- vsync  in  1  frame sync, synchronous to clk.
- reg_valid  in  NUM_REGIONS  per-region enable.
- reg_base  in  NUM_REGIONS*ADDR_W  region start word address.
- reg_len  in  NUM_REGIONS*CNT_W  words to write.
- reg_mode  in  NUM_REGIONS*2  0 CONST, 1 INC, 2 DIV, 3 MOD.
- reg_seed  in  NUM_REGIONS*DATA_W  base data value.
- reg_step  in  NUM_REGIONS*CNT_W  step, divisor or modulus.
- busy  out  1  high in DELAY/FILL.
- done  out  1  high in SCROLL.
- mem_en  out  1  request valid.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_din  out  DATA_W  write data.
- mem_ready  in  1  request accepted this cycle.

Behaviour:
- Reset: state IDLE; all outputs 0; counters, scroll x/y and frame counter cleared.
- Reset asserted mid-transfer aborts immediately; no completion write.
- States: IDLE -> DELAY -> FILL -> SCROLL.
- IDLE leaves on start, or on the first cycle after reset release if AUTO_START.
- DELAY counts STARTUP_DELAY cycles. If STARTUP_DELAY is 0, go directly to FILL.
- FILL walks regions 0..NUM_REGIONS-1.
  - A region with reg_valid=0 or reg_len=0 is skipped; evaluation takes 1 cycle and issues no mem_en.
  - Config is sampled at region entry and must stay stable while busy.
- Word k (0..len-1) of a region:
  - mem_addr = base+k (mod 2^ADDR_W).
  - mem_din is computed mod 2^DATA_W from incremental counters; no dividers.
    - CONST: seed.
    - INC: seed + k*step.
    - DIV: seed + floor(k/step).
    - MOD: seed + (k mod step).
    - DIV/MOD with step=0: seed.
- Handshake:
  - mem_en=mem_we=1 and addr/din are held stable until a cycle with mem_ready=1.
  - k advances only on accept.
  - Back-to-back accepts give 1 word per cycle.
  - The first word is presented the cycle after region entry.
- After the last region: go to SCROLL; mem_en=0 on the first SCROLL cycle.
- SCROLL, edge detect:
  - Register vsync; a rising edge is vsync & ~prev.
  - Each edge increments frame_cnt.
  - When frame_cnt reaches FRAMES_PER_STEP-1 on an edge: frame_cnt<=0, x<=x+1 (9-bit, wraps 511->0), y<=y+1 (8-bit, wraps 255->0).
- SCROLL, write:
  - Every edge (step or not) latches data SCROLL_FLAGS|(x_new<<8)|y_new and raises a pending write to SCROLL_ADDR, held until mem_ready.
  - An edge arriving while a write is pending updates the counters and overwrites the pending data; no second write is queued.
- start in SCROLL: return to DELAY; scroll x/y retained; frame_cnt cleared.
- start in DELAY/FILL: ignored.
- start the same cycle as an accept: accept completes normally.
- busy=1 in DELAY/FILL; done=1 only in SCROLL.

Test Plan:
- Reset with AUTO_START=1, STARTUP_DELAY=100, region0 valid base=0x0610_0000 len=4 CONST seed=5, mem_ready=1 -> no mem_en for 100 cycles, then 4 consecutive writes 0x0610_0000..0003 data 5, then done=1.
- Region INC seed=0x10 step=3 len=5 -> data 0x10,0x13,0x16,0x19,0x1C; region DIV step=64 len=130 -> data 0 (k<64), 1 (64..127), 2 (128,129); region MOD step=7 len=9 -> data 0..6,0,1.
- Backpressure: mem_ready toggles 1-0-0-1 during INC fill -> addr/din held across stall cycles; no word skipped or duplicated; total writes equal len.
- Regions 1 and 3 with reg_valid=0, region 2 len=0 -> no writes to their bases; regions 0 and 4 written contiguously in order.
- SCROLL with FRAMES_PER_STEP=4: 4 vsync pulses -> 4 writes to SCROLL_ADDR; 4th data 0x8000_0101. After 512 steps x wraps to 0, y reads 0 (512 mod 256).
- Assert rst in mid-FILL word 2 -> outputs 0 asynchronously; after release the sequence restarts from DELAY with word 0 of region 0.
